div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle controller for the EX-stage divide path. It accepts a DIV/DIVU request from `ex` through a start/ready handshake and runs a 32-step restoring division on latched operand magnitudes. It applies the sign correction and returns a 64-bit {remainder, quotient} result for the HI/LO write. It owns the sequencing state machine, the iteration counter, operand capture, divide-by-zero short-circuit and pipeline-flush annulment; `ex` holds `stallreq` while ready is low.

## Interface
- `DIV_STEPS`, default 32: number of quotient bits produced, one per cycle.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-low.
- `start_i` input 1: divide request, held high by `ex` until `ready_o` is seen.
- `signed_div_i` input 1: 1 selects DIV, 0 selects DIVU.
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `annul_i` input 1: flush; aborts any operation not yet in END.
- `result_o` output 64: {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready_o` output 1: result valid.
- `busy_o` output 1: state is not IDLE.

## Operation
- States, 2-bit: IDLE, BYZERO, ON, END.
- **IDLE**
  - `start_i` && !`annul_i` && `opdata2_i`==0 → BYZERO.
  - `start_i` && !`annul_i` && divisor nonzero → ON, with the following captured:
    - cnt=0.
    - Operand magnitudes: two's-complement negate when `signed_div_i` and bit 31 is set.
    - Original sign bits and `signed_div_i`.
    - 65-bit work register = {32'b0, |dividend|, 1'b0}.
  - Otherwise stay in IDLE.
- **ON**
  - `annul_i` → IDLE; the work register is discarded and `ready_o` stays 0.
  - While cnt < 32, each cycle:
    - trial = {1'b0, work[63:32]} − {1'b0, |divisor|}.
    - trial[32]=1: work ← {work[63:0], 1'b0}.
    - trial[32]=0: work ← {trial[31:0], work[31:0], 1'b1}.
    - cnt ← cnt+1.
  - At cnt == 32:
    - quotient = work[31:0], negated if signed && sign1≠sign2.
    - remainder = work[64:33], negated if signed && sign1=1.
    - Register `result_o`, set `ready_o`=1, → END.
- **BYZERO**: `result_o` ← 0, `ready_o` ← 1, → END. The MIPS result is undefined; the block returns zero deterministically.
- **END**
  - Hold `result_o`/`ready_o` while `start_i`=1.
  - `start_i`=0 → IDLE, with `ready_o` ← 0 and `result_o` ← 0.
  - `annul_i` is ignored in END.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap is raised.
- All arithmetic is unsigned 33-bit on magnitudes; the sign is applied only at the end.

## Timing
- Reset (`rst`=0 at a rising edge) forces, next cycle:
  - state IDLE, cnt 0, work 0.
  - `result_o` 0, `ready_o` 0, `busy_o` 0.
- Reset mid-operation aborts with no result.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Nonzero divisor, start sampled at the edge ending cycle N:
  - ON from N+1.
  - Steps on the edges ending N+1…N+32.
  - `ready_o`=1 from cycle N+34.
- Zero divisor: `ready_o`=1 from cycle N+2.
- `ready_o` stays high until the first edge at which `start_i`=0 is sampled. It falls one cycle after `start_i` drops.
- A new start is accepted on the edge after the return to IDLE; back-to-back throughput is 35 cycles.
- Operand inputs are ignored outside IDLE. `ex` may change them freely after the capture edge.
- `annul_i` and `start_i` both high in IDLE: the request is dropped.

## Structure
- Shared constants go in `defines.v`:
  - state encodings DivFree/DivByZero/DivOn/DivEnd.
  - DivStart/DivStop.
  - DivResultReady/DivResultNotReady.
- `DIV_STEPS` width of cnt = 6 bits.
- One sub-module, `div_step`: combinational trial subtract plus next-work-register mux (65-bit in, 65-bit out). `div_ctrl` keeps the FSM, counter, capture and sign fix.

## Test plan
- DIVU 100 / 7 → after 34 cycles `result_o` = {32'd2, 32'd14}; `ready_o` held until start drops, then 0 one cycle later.
- DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); DIV 7 / −2 → quotient −3, remainder 1.
- Divisor 0, start high → `ready_o` at N+2, `result_o` = 0; DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- `annul_i` pulsed at step 10 of DIVU 0xFFFFFFFF / 3 → IDLE next cycle, `ready_o` never rises; an immediate new DIVU 9 / 3 yields {0, 3}.
- `rst`=0 for one cycle at step 20 → all outputs 0 next cycle, state IDLE; `rst` asserted with `start_i` high causes no capture.
- Operands changed every cycle after capture during DIVU 1000 / 10 → result {0, 100} unaffected.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: constants, state encoding and helpers shared by the
// divide controller, its datapath step and the testbench.
//   div_state_e       : 2-bit sequencer state (DivFree/DivByZero/DivOn/DivEnd)
//   DivStart/DivStop  : levels of the start request
//   DivResultReady/NotReady : levels of the ready flag
//   abs_val / neg_if  : two's-complement magnitude and conditional negate
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int CntWidth = 6;

    // Magnitude of a 32-bit operand; only signed operands with bit 31 set
    // are negated, so DIVU treats every value as already positive.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic do_neg);
        return do_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request/result bundle between the EX stage and the divider.
//   start_i, signed_div_i, opdata1_i, opdata2_i, annul_i : EX -> divider
//   result_o {remainder, quotient}, ready_o, busy_o      : divider -> EX
//   master : EX-stage view    slave : divider view
interface div_ctrl_if;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, purely combinational.
//   work_i    : 65-bit work register {partial remainder, dividend/quotient, 0}
//   divisor_i : 32-bit divisor magnitude
//   work_o    : work register after this step
module div_step (
    input  logic [64:0] work_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] work_o
);

    logic [32:0] trial;
    logic        unused_msb;

    // Bit 64 is shifted out every step; it only matters when the final
    // remainder is read from work[64:33].
    assign unused_msb = work_i[64];

    assign trial = {1'b0, work_i[63:32]} - {1'b0, divisor_i};

    // A borrow (trial[32]) means the divisor did not fit: keep the partial
    // remainder and shift in a 0 quotient bit; otherwise commit the
    // difference and shift in a 1.
    assign work_o = trial[32] ? {work_i[63:0], 1'b0}
                              : {trial[31:0], work_i[31:0], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage.
//   clk       : clock
//   rst       : synchronous active-low reset
//   bus       : div_ctrl_if.slave (start/operands/annul in, result/ready/busy out)
// Operands are captured as magnitudes in IDLE, DIV_STEPS restoring steps
// run in ON, and the sign correction is applied when the result is
// registered. A zero divisor short-circuits to a zero result.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus
);

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DIV_STEPS);

    div_state_e          state_q,   state_d;
    logic [CntWidth-1:0] cnt_q,     cnt_d;
    logic [64:0]         work_q,    work_d;
    logic [31:0]         divisor_q, divisor_d;
    logic                sign1_q,   sign1_d;
    logic                sign2_q,   sign2_d;
    logic                signed_q,  signed_d;
    logic [63:0]         result_q,  result_d;
    logic                ready_q,   ready_d;
    logic [64:0]         work_step;

    div_step u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        signed_d  = signed_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        divisor_d = abs_val(bus.opdata2_i, bus.signed_div_i);
                        sign1_d   = bus.opdata1_i[31];
                        sign2_d   = bus.opdata2_i[31];
                        signed_d  = bus.signed_div_i;
                        work_d    = {32'd0, abs_val(bus.opdata1_i, bus.signed_div_i), 1'b0};
                    end
                end
            end

            DivByZero: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                end else begin
                    result_d = '0;
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end

            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                    work_d  = '0;
                end else if (cnt_q != LastCnt) begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    // Remainder takes the dividend's sign; quotient is
                    // negative only when the operand signs differ.
                    result_d = {neg_if(work_q[64:33], signed_q && sign1_q),
                                neg_if(work_q[31:0],  signed_q && (sign1_q ^ sign2_q))};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end

            DivEnd: begin
                // Annul is deliberately ignored here: the result is final.
                if (bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end

            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = (state_q != DivFree);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lat;

    always #5 clk = ~clk;

    div_ctrl_if bus();

    div_ctrl #(.DIV_STEPS(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at a falling edge and return right after the capture edge.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        @(posedge clk);
    endtask

    // k = number of edges after the capture edge before ready is seen.
    task automatic wait_ready(input bit scramble, output int k);
        k = 0;
        @(negedge clk);
        while (!bus.ready_o && k < 100) begin
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
    endtask

    // Check result, hold start one more cycle, then drop it and check clear.
    task automatic finish_op(input string tag, input logic [63:0] exp);
        check({tag, "_result"}, bus.result_o, exp);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        check({tag, "_ready_hold"}, 64'(bus.ready_o), 64'd1);
        check({tag, "_result_hold"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_result_clr"}, bus.result_o, 64'd0);
        check({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst = 1'b1;

        // DIVU 100 / 7
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(1'b0, lat);
        check("divu_100_7_lat", 64'(lat), 64'd33);
        finish_op("divu_100_7", {32'd2, 32'd14});

        // DIV -7 / 2
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_ready(1'b0, lat);
        check("div_m7_2_lat", 64'(lat), 64'd33);
        finish_op("div_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // DIV 7 / -2
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_ready(1'b0, lat);
        finish_op("div_7_m2", {32'h0000_0001, 32'hFFFF_FFFD});

        // DIV -100 / -7
        launch(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_ready(1'b0, lat);
        finish_op("div_m100_m7", {32'hFFFF_FFFE, 32'h0000_000E});

        // Divide by zero short-circuit
        launch(1'b0, 32'd12345, 32'd0);
        wait_ready(1'b0, lat);
        check("divzero_lat", 64'(lat), 64'd1);
        finish_op("divzero", 64'd0);

        // Signed overflow case
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(1'b0, lat);
        finish_op("div_ovf", {32'h0000_0000, 32'h8000_0000});

        // DIVU max / 16
        launch(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_ready(1'b0, lat);
        finish_op("divu_max_16", {32'h0000_000F, 32'h0FFF_FFFF});

        // Annul at step 10, then an immediate new DIVU 9 / 3
        launch(1'b0, 32'hFFFF_FFFF, 32'd3);
        repeat (11) @(negedge clk);
        check("annul_pre_ready", 64'(bus.ready_o), 64'd0);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_idle", 64'(bus.busy_o), 64'd0);
        check("annul_no_ready", 64'(bus.ready_o), 64'd0);
        bus.annul_i   = 1'b0;
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        @(posedge clk);
        wait_ready(1'b0, lat);
        check("after_annul_lat", 64'(lat), 64'd33);
        finish_op("after_annul", {32'd0, 32'd3});

        // Operands scrambled after capture
        launch(1'b0, 32'd1000, 32'd10);
        wait_ready(1'b1, lat);
        check("scramble_lat", 64'(lat), 64'd33);
        finish_op("scramble", {32'd0, 32'd100});

        // Reset mid-operation, then reset held with start high
        launch(1'b0, 32'd1000, 32'd7);
        repeat (21) @(negedge clk);
        check("rst_pre_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", bus.result_o, 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        check("rst_no_capture", 64'(bus.busy_o), 64'd0);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("rst_release_idle", 64'(bus.busy_o), 64'd0);
        check("rst_release_ready", 64'(bus.ready_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
